// File: rtl/wide_add_pkg.sv
// Shared types and defaults for the multi-beat wide adder.
// Holds the sequencer state encoding and the beat-counter width helper.
package wide_add_pkg;

   localparam int DEF_SLICE_W = 16;
   localparam int DEF_WORDS   = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} wadd_state_t;

   // Beat counter is never narrower than one bit, so WORDS=1 still has a register.
   function automatic int beat_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand request and result handshake bundle for the wide adder sequencer.
// The master drives operands and result acceptance; the slave is the sequencer.
interface wide_add_sequencer_if
   import wide_add_pkg::*;
#(
   parameter int SLICE_W = DEF_SLICE_W,
   parameter int WORDS   = DEF_WORDS
);
   localparam int W = SLICE_W * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         busy;

   modport master (
      output in_valid, op_a, op_b, sub, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow, busy
   );

   modport slave (
      input  in_valid, op_a, op_b, sub, out_ready,
      output in_ready, out_valid, result, carry_out, overflow, busy
   );

endinterface

// File: rtl/wide_add_sequencer_add_slice.sv
// Combinational SLICE_W-bit ripple-carry adder slice: a + b + cin -> {cout, sum}.
// Zero latency; no handshake.
module add_slice #(
   parameter int SLICE_W = 16
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   logic [SLICE_W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[SLICE_W];

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract over WORDS beats of one shared slice, LSB slice first; result valid WORDS edges after accept.
// Accepts only in IDLE; the result is held in DONE until out_ready, one operation in flight.
module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter int SLICE_W = DEF_SLICE_W,
   parameter int WORDS   = DEF_WORDS
) (
   input logic                clk,
   input logic                rst,
   wide_add_sequencer_if.slave bus
);

   localparam int            BW        = beat_width(WORDS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);

   wadd_state_t                  state;
   wadd_state_t                  state_nxt;
   logic [BW-1:0]                beat;
   logic                         carry;
   logic [WORDS-1:0][SLICE_W-1:0] a_q;
   logic [WORDS-1:0][SLICE_W-1:0] b_q;
   logic [WORDS-1:0][SLICE_W-1:0] res_q;
   logic                         carry_out_q;
   logic                         overflow_q;

   logic [SLICE_W-1:0]           s;
   logic                         c;
   logic                         accept;
   logic                         step;
   logic                         last;

   add_slice #(.SLICE_W(SLICE_W)) u_slice (
      .a    (a_q[beat]),
      .b    (b_q[beat]),
      .cin  (carry),
      .sum  (s),
      .cout (c)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      step          = 1'b0;
      last          = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            bus.busy = 1'b1;
            step     = 1'b1;
            if (beat == LAST_BEAT) begin
               last      = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // While reset is held the block already looks idle to both neighbours.
      if (rst) begin
         bus.in_ready  = 1'b1;
         bus.busy      = 1'b0;
         bus.out_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat        <= '0;
         carry       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= bus.op_a;
            b_q   <= bus.sub ? ~bus.op_b : bus.op_b;
            carry <= bus.sub;
            beat  <= '0;
         end
         if (step) begin
            res_q[beat] <= s;
            carry       <= c;
            beat        <= last ? '0 : beat + 1'b1;
            if (last) begin
               carry_out_q <= c;
               overflow_q  <= (a_q[WORDS-1][SLICE_W-1] == b_q[WORDS-1][SLICE_W-1]) &&
                              (s[SLICE_W-1] != a_q[WORDS-1][SLICE_W-1]);
            end
         end
      end
   end

   assign bus.result    = res_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with SLICE_W=16, WORDS=4.
module tb_wide_add_sequencer;

   localparam int SLICE_W = 16;
   localparam int WORDS   = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   wide_add_sequencer_if #(.SLICE_W(SLICE_W), .WORDS(WORDS)) bus ();

   wide_add_sequencer #(.SLICE_W(SLICE_W), .WORDS(WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_valid(output int k);
      k = 0;
      while (bus.out_valid !== 1'b1 && k < 20) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
   endtask

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic [63:0] er, input logic eco, input logic eov,
                         input string nm);
      int k;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL %s in_ready before accept: got %b want 1", nm, bus.in_ready);
      end
      bus.op_a = a; bus.op_b = b; bus.sub = s; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op_a = '0; bus.op_b = '0; bus.sub = 1'b0;
      wait_valid(k);
      checks++;
      if (k != WORDS) begin
         errors++; $display("FAIL %s latency: got %0d edges want %0d", nm, k, WORDS);
      end
      checks++;
      if (bus.result !== er) begin
         errors++; $display("FAIL %s result: got %h want %h", nm, bus.result, er);
      end
      checks++;
      if (bus.carry_out !== eco) begin
         errors++; $display("FAIL %s carry_out: got %b want %b", nm, bus.carry_out, eco);
      end
      checks++;
      if (bus.overflow !== eov) begin
         errors++; $display("FAIL %s overflow: got %b want %b", nm, bus.overflow, eov);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL %s after handshake: out_valid=%b in_ready=%b want 0/1",
                            nm, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset handshake: in_ready=%b busy=%b out_valid=%b want 1/0/0",
                            bus.in_ready, bus.busy, bus.out_valid);
      end
      checks++;
      if (bus.result !== 64'h0 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
         errors++; $display("FAIL reset outputs: result=%h co=%b ov=%b want 0/0/0",
                            bus.result, bus.carry_out, bus.overflow);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, "add_slice_carry");
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, "add_full_ripple");
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "add_overflow");
   endtask

   task automatic test_sub();
      run_op(64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
      run_op(64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, "sub_no_borrow");
      run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "sub_overflow");
   endtask

   task automatic test_backpressure();
      int k;
      @(negedge clk);
      bus.op_a = 64'h1234; bus.op_b = 64'h1111; bus.sub = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // Keep a second request pending with different operands for the whole stall.
      bus.op_a = 64'd3; bus.op_b = 64'd4;
      wait_valid(k);
      checks++;
      if (k != WORDS) begin
         errors++; $display("FAIL bp latency: got %0d want %0d", k, WORDS);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 64'h2345) begin
            errors++; $display("FAIL bp hold cycle %0d: out_valid=%b in_ready=%b result=%h want 1/0/2345",
                               i, bus.out_valid, bus.in_ready, bus.result);
         end
         @(posedge clk);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp no overlap: busy=%b in_ready=%b out_valid=%b want 0/1/0",
                            bus.busy, bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL bp pending accept: busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready);
      end
      wait_valid(k);
      checks++;
      if (bus.result !== 64'd7 || k != WORDS) begin
         errors++; $display("FAIL bp pending op: result=%h edges=%0d want 7/%0d", bus.result, k, WORDS);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int k;
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.op_a = 64'd1; bus.op_b = 64'd2; bus.sub = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wait_valid(k);
      checks++;
      if (bus.result !== 64'd3 || k != WORDS) begin
         errors++; $display("FAIL b2b first: result=%h edges=%0d want 3/%0d", bus.result, k, WORDS);
      end
      bus.op_a = 64'd10; bus.op_b = 64'd20;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b done one cycle: out_valid=%b in_ready=%b want 0/1",
                            bus.out_valid, bus.in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(k);
      checks++;
      if (bus.result !== 64'd30 || k != WORDS) begin
         errors++; $display("FAIL b2b second: result=%h edges=%0d want 30/%0d", bus.result, k, WORDS);
      end
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b second done one cycle: out_valid=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.op_a = 64'hAAAA_BBBB_CCCC_DDDD; bus.op_b = 64'h1111_1111_1111_1111; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      // Now in RUN with beat 2 active.
      checks++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL midrst running: busy=%b out_valid=%b want 1/0", bus.busy, bus.out_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL midrst during reset: in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.result !== 64'h0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL midrst after: out_valid=%b result=%h in_ready=%b busy=%b want 0/0/1/0",
                            bus.out_valid, bus.result, bus.in_ready, bus.busy);
      end
      run_op(64'h0000_0001_0000_FFFF, 64'h0000_0002_0000_0001, 1'b0,
             64'h0000_0003_0001_0000, 1'b0, 1'b0, "midrst_fresh");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
